// File: rtl/program_fetch_unit_if.sv
// Fetch-stage bus: redirect/back-pressure/load inputs and registered fetch outputs.
// The extra fault output exists only when FETCH_FAULT_EN is defined.
interface program_fetch_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 6
);
    logic              hlt;
    logic              redirect;
    logic [XLEN-1:0]   target;
    logic              if_ready;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [XLEN-1:0]   load_data;
    logic              if_valid;
    logic [XLEN-1:0]   if_instr;
    logic [XLEN-1:0]   if_pc;
    logic [XLEN-1:0]   if_pc_next;
    logic              halted;
`ifdef FETCH_FAULT_EN
    logic              fault;
`endif

    modport master (
        output hlt, redirect, target, if_ready, load_en, load_addr, load_data,
`ifdef FETCH_FAULT_EN
        input  fault,
`endif
        input  if_valid, if_instr, if_pc, if_pc_next, halted
    );

    modport slave (
        input  hlt, redirect, target, if_ready, load_en, load_addr, load_data,
`ifdef FETCH_FAULT_EN
        output fault,
`endif
        output if_valid, if_instr, if_pc, if_pc_next, halted
    );
endinterface

// File: rtl/program_fetch_unit.sv
// Instruction fetch stage: PC, loadable instruction memory, registered valid/ready output.
// FETCH_FAULT_EN: out-of-range fetches trap into a FAULT state instead of returning NOP_WORD.
module program_fetch_unit #(
    parameter int unsigned    XLEN       = 32,
    parameter int unsigned    IMEM_DEPTH = 64,
    parameter int unsigned    ADDR_W     = 6,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_WORD  = XLEN'(32'h13)
) (
    input logic                clk,
    input logic                rst,
    program_fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {StRun, StHalted, StFault} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_next_q, pc_next_d;
    logic            valid_q, valid_d;

    logic [XLEN-1:0] mem_q [IMEM_DEPTH];

    logic            advance;
    logic            in_range;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] fetch_word;

    assign advance    = ~valid_q | bus.if_ready;
    assign fetch_addr = bus.redirect ? bus.target : fetch_pc_q;
    assign in_range   = fetch_addr < XLEN'(IMEM_DEPTH);
    assign fetch_word = in_range ? mem_q[fetch_addr[ADDR_W-1:0]] : NOP_WORD;

    // Memory is never reset and keeps accepting writes while hlt is high.
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_next_d  = pc_next_q;
        valid_d    = valid_q;
        if (!bus.hlt) begin
            unique case (state_q)
                StRun: begin
                    // Redirect wins over a stall: the held instruction is dropped.
                    if (bus.redirect || advance) begin
`ifdef FETCH_FAULT_EN
                        if (!in_range) begin
                            state_d = StFault;
                            valid_d = 1'b0;
                            pc_d    = fetch_addr;
                        end else
`endif
                        begin
                            instr_d    = fetch_word;
                            pc_d       = fetch_addr;
                            pc_next_d  = fetch_addr + XLEN'(1);
                            fetch_pc_d = fetch_addr + XLEN'(1);
                            valid_d    = 1'b1;
                            if (fetch_word[6:0] == 7'h7F) begin
                                state_d = StHalted;
                            end
                        end
                    end
                end
                StHalted: begin
                    if (valid_q && bus.if_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            instr_q    <= NOP_WORD;
            pc_q       <= RESET_PC;
            pc_next_q  <= RESET_PC + XLEN'(1);
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_next_q  <= pc_next_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.if_valid   = valid_q;
    assign bus.if_instr   = instr_q;
    assign bus.if_pc      = pc_q;
    assign bus.if_pc_next = pc_next_q;
    assign bus.halted     = (state_q == StHalted);
`ifdef FETCH_FAULT_EN
    assign bus.fault      = (state_q == StFault);
`endif
endmodule

// File: tb/tb_program_fetch_unit.sv
// Directed bench for program_fetch_unit: sequencing, stall, redirect, hlt, halt, range, reset.
module tb_program_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_mem [64];

    always #5 clk = ~clk;

    program_fetch_unit_if #(.XLEN(32), .ADDR_W(6)) bus ();

    program_fetch_unit #(
        .XLEN      (32),
        .IMEM_DEPTH(64),
        .ADDR_W    (6),
        .RESET_PC  (32'h0),
        .NOP_WORD  (32'h13)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr, input logic h);
        chk({tag, ".valid"}, {31'd0, bus.if_valid}, {31'd0, v});
        chk({tag, ".pc"}, bus.if_pc, pc);
        chk({tag, ".pc_next"}, bus.if_pc_next, pc + 32'd1);
        chk({tag, ".instr"}, bus.if_instr, instr);
        chk({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, h});
    endtask

    initial begin
        bus.hlt = 1'b0; bus.redirect = 1'b0; bus.target = '0; bus.if_ready = 1'b1;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;

        // Program: addi x0,x0,i at word i; HALT (0x7F) at 3 and 13; marker at 63.
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h13 | (32'(i) << 20);
        exp_mem[3]  = 32'h7F;
        exp_mem[13] = 32'h7F;
        exp_mem[63] = 32'h3F00_0013;
        #1;
        for (int i = 0; i < 64; i++) begin
            if (i < 16 || i == 63) begin
                bus.load_en = 1'b1; bus.load_addr = 6'(i); bus.load_data = exp_mem[i];
                step();
            end
        end
        bus.load_en = 1'b0;
        chk_out("reset", 1'b0, 32'd0, 32'h13, 1'b0);

        // Sequential run into HALT at word 3.
        rst = 1'b0;
        step(); chk_out("seq0", 1'b1, 32'd0, exp_mem[0], 1'b0);
        step(); chk_out("seq1", 1'b1, 32'd1, exp_mem[1], 1'b0);
        step(); chk_out("seq2", 1'b1, 32'd2, exp_mem[2], 1'b0);
        step(); chk_out("seq3", 1'b1, 32'd3, 32'h7F, 1'b1);
        step(); chk_out("halt_drop", 1'b0, 32'd3, 32'h7F, 1'b1);
        bus.redirect = 1'b1; bus.target = 32'd10;
        step(); chk_out("halt_redir", 1'b0, 32'd3, 32'h7F, 1'b1);
        bus.redirect = 1'b0;

        // Async reset between edges clears outputs immediately.
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 32'd0, 32'h13, 1'b0);
        #1;
        rst = 1'b0;

        // Stall at pc=1 for three cycles, then resume without skip or duplicate.
        step(); chk_out("r_seq0", 1'b1, 32'd0, exp_mem[0], 1'b0);
        step(); chk_out("r_seq1", 1'b1, 32'd1, exp_mem[1], 1'b0);
        bus.if_ready = 1'b0;
        step(); chk_out("stall_a", 1'b1, 32'd1, exp_mem[1], 1'b0);
        step(); chk_out("stall_b", 1'b1, 32'd1, exp_mem[1], 1'b0);
        step(); chk_out("stall_c", 1'b1, 32'd1, exp_mem[1], 1'b0);
        bus.if_ready = 1'b1;
        step(); chk_out("resume", 1'b1, 32'd2, exp_mem[2], 1'b0);

        // Redirect overrides a stall with no bubble.
        bus.if_ready = 1'b0; bus.redirect = 1'b1; bus.target = 32'd10;
        step(); chk_out("redir", 1'b1, 32'd10, exp_mem[10], 1'b0);
        bus.if_ready = 1'b1; bus.redirect = 1'b0;
        step(); chk_out("post_redir", 1'b1, 32'd11, exp_mem[11], 1'b0);

        // hlt freezes everything but the load port.
        bus.hlt = 1'b1; bus.load_en = 1'b1; bus.load_addr = 6'd12; bus.load_data = 32'hDEAD_0013;
        step(); chk_out("hlt_a", 1'b1, 32'd11, exp_mem[11], 1'b0);
        bus.load_en = 1'b0;
        step(); chk_out("hlt_b", 1'b1, 32'd11, exp_mem[11], 1'b0);
        bus.hlt = 1'b0;
        step(); chk_out("hlt_resume", 1'b1, 32'd12, 32'hDEAD_0013, 1'b0);
        step(); chk_out("halt13", 1'b1, 32'd13, 32'h7F, 1'b1);

        // Read-before-write at the last in-range word, then out-of-range fetch.
        rst = 1'b1; #1; rst = 1'b0;
        step(); chk_out("r2_seq0", 1'b1, 32'd0, exp_mem[0], 1'b0);
        bus.redirect = 1'b1; bus.target = 32'd63;
        bus.load_en = 1'b1; bus.load_addr = 6'd63; bus.load_data = 32'h5500_0013;
        step(); chk_out("rbw_old", 1'b1, 32'd63, exp_mem[63], 1'b0);
        bus.load_en = 1'b0;
        step(); chk_out("rbw_new", 1'b1, 32'd63, 32'h5500_0013, 1'b0);
        bus.target = 32'd64;
        step();
`ifdef FETCH_FAULT_EN
        chk("oor.fault", {31'd0, bus.fault}, 32'd1);
        chk("oor.valid", {31'd0, bus.if_valid}, 32'd0);
        chk("oor.pc", bus.if_pc, 32'd64);
        bus.redirect = 1'b0;
        step();
        chk("oor_hold.fault", {31'd0, bus.fault}, 32'd1);
        chk("oor_hold.valid", {31'd0, bus.if_valid}, 32'd0);
        chk("oor_hold.pc", bus.if_pc, 32'd64);
`else
        chk_out("oor64", 1'b1, 32'd64, 32'h13, 1'b0);
        bus.redirect = 1'b0;
        step(); chk_out("oor65", 1'b1, 32'd65, 32'h13, 1'b0);
        bus.redirect = 1'b1; bus.target = 32'hFFFF_FFFF;
        step(); chk_out("wrap_top", 1'b1, 32'hFFFF_FFFF, 32'h13, 1'b0);
        chk("wrap_top.pc_next0", bus.if_pc_next, 32'd0);
        bus.redirect = 1'b0;
        step(); chk_out("wrap_zero", 1'b1, 32'd0, exp_mem[0], 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
